// File: rtl/inst_sram_axi_bridge.sv
// Read-only bridge from the IF stage's SRAM-like fetch port to a single-ID AXI read master.
// Accepted addresses are held on AR until the handshake; an outstanding count filters stale R beats.
module inst_sram_axi_bridge #(
  parameter int         MAX_OUTSTANDING = 2,
  parameter logic [3:0] ARID_VAL        = 4'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic {AR_IDLE, AR_SEND} ar_state_e;

  localparam logic [1:0] MaxCnt = 2'(MAX_OUTSTANDING);

  ar_state_e   state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;

  // Write-side and response-status inputs have no function in a fetch-only bridge.
  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wstrb, inst_sram_wdata, rid, rresp, rlast};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= AR_IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= 32'd0;
      size_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    // A new address can only be taken when AR is free now or frees this cycle.
    inst_sram_addr_ok = resetn & inst_sram_req & ~inst_sram_wr & (cnt_q < MaxCnt) &
                        ((state_q == AR_IDLE) | arready);
    inst_sram_data_ok = rvalid & (cnt_q != 2'd0);
    if (inst_sram_addr_ok) begin
      state_d = AR_SEND;
      addr_d  = inst_sram_addr;
      size_d  = inst_sram_size;
    end else if ((state_q == AR_SEND) && arready) begin
      state_d = AR_IDLE;
    end
    cnt_d = cnt_q + {1'b0, inst_sram_addr_ok} - {1'b0, inst_sram_data_ok};
  end

  assign inst_sram_rdata = rdata;
  assign rready          = 1'b1;

  assign arid    = ARID_VAL;
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, size_q};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = (state_q == AR_SEND);

endmodule

// File: tb/tb_inst_sram_axi_bridge.sv
// Randomized and directed bench for inst_sram_axi_bridge against an in-order fetch reference model.
module tb_inst_sram_axi_bridge;

  localparam int         MAX  = 2;
  localparam logic [3:0] ARID = 4'h5;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req, wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: accepted-but-unreturned fetches, in order, plus the address waiting on AR.
  int          m_cnt;
  bit          m_pend;
  logic [31:0] m_araddr;
  logic [1:0]  m_size;
  logic [31:0] m_order[$];
  logic [31:0] sq[$];
  bit          e_ok, e_dok;

  always #5 clk = ~clk;

  inst_sram_axi_bridge #(.MAX_OUTSTANDING(MAX), .ARID_VAL(ARID)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(req), .inst_sram_wr(wr), .inst_sram_size(size),
    .inst_sram_wstrb(wstrb), .inst_sram_addr(addr), .inst_sram_wdata(wdata),
    .inst_sram_addr_ok(addr_ok), .inst_sram_data_ok(data_ok), .inst_sram_rdata(sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_pend = 0; m_araddr = 0; m_size = 0;
    m_order.delete(); sq.delete();
  endtask

  task automatic predict();
    e_ok  = resetn && req && !wr && (m_cnt < MAX) && (!m_pend || arready);
    e_dok = rvalid && (m_cnt != 0);
  endtask

  task automatic cyc(input bit rq, input bit w, input logic [31:0] a, input logic [1:0] sz,
                     input bit ary, input bit rv, input logic [31:0] rd);
    @(negedge clk);
    req = rq; wr = w; addr = a; size = sz; arready = ary; rvalid = rv; rdata = rd;
    wstrb = 4'($urandom); wdata = $urandom; rid = 4'($urandom); rresp = 2'($urandom);
    rlast = 1'($urandom);
    #1;
    predict();
  endtask

  task automatic commit();
    if (arvalid && arready) sq.push_back(araddr);
    if (rvalid && sq.size() > 0) void'(sq.pop_front());
    @(posedge clk);
    if (m_pend && arready) m_pend = 0;
    if (e_ok) begin
      m_pend = 1; m_araddr = addr; m_size = size; m_order.push_back(addr);
    end
    if (e_dok) void'(m_order.pop_front());
    m_cnt = m_cnt + int'(e_ok) - int'(e_dok);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; req = 0; wr = 0; arready = 0; rvalid = 0;
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && m_cnt > 0; i++) begin
      cyc(0, 0, 0, 2, 1, sq.size() > 0, sq.size() > 0 ? word_of(sq[0]) : 32'h0);
      commit();
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetn = 1'b0; req = 1; wr = 0; addr = 32'h1c00_0000; size = 2; arready = 1;
    rvalid = 1; rdata = 32'hdead_beef;
    model_reset();
    #1;
    vectors++;
    if (addr_ok !== 1'b0 || arvalid !== 1'b0 || data_ok !== 1'b0 || rready !== 1'b1)
      begin miscompares++; $display("FAIL reset_ctrl addr_ok=%b arvalid=%b data_ok=%b rready=%b want 0 0 0 1", addr_ok, arvalid, data_ok, rready); end
    vectors++;
    if (araddr !== 32'd0 || arsize !== 3'd0 || arlen !== 8'd0 || arburst !== 2'b01 ||
        arid !== ARID || arlock !== 2'd0 || arcache !== 4'd0 || arprot !== 3'd0)
      begin miscompares++; $display("FAIL reset_ar araddr=%h arsize=%0d arlen=%0d arburst=%b arid=%h", araddr, arsize, arlen, arburst, arid); end
    @(negedge clk);
    resetn = 1'b1; req = 0; rvalid = 0;
  endtask

  task automatic test_single_fetch();
    do_reset();
    cyc(1, 0, 32'h1c00_0000, 2, 1, 0, 0);
    vectors++;
    if (addr_ok !== 1'b1 || arvalid !== 1'b0)
      begin miscompares++; $display("FAIL single_accept addr_ok=%b arvalid=%b want 1 0", addr_ok, arvalid); end
    commit();
    cyc(0, 0, 0, 0, 1, 0, 0);
    vectors++;
    if (arvalid !== 1'b1 || araddr !== 32'h1c00_0000 || arsize !== 3'b010 || arlen !== 8'd0)
      begin miscompares++; $display("FAIL single_ar arvalid=%b araddr=%h arsize=%b arlen=%0d", arvalid, araddr, arsize, arlen); end
    commit();
    cyc(0, 0, 0, 0, 1, 1, 32'h0280_0c0c);
    vectors++;
    if (data_ok !== 1'b1 || sram_rdata !== 32'h0280_0c0c || arvalid !== 1'b0)
      begin miscompares++; $display("FAIL single_data data_ok=%b rdata=%h arvalid=%b want 1 02800c0c 0", data_ok, sram_rdata, arvalid); end
    commit();
    cyc(0, 0, 0, 0, 1, 1, 32'h1111_2222);
    vectors++;
    if (data_ok !== 1'b0)
      begin miscompares++; $display("FAIL single_cnt_zero data_ok=%b want 0", data_ok); end
    commit();
  endtask

  task automatic test_backpressure();
    logic [31:0] a;
    do_reset();
    a = 32'h1c00_0040;
    cyc(1, 0, a, 2, 0, 0, 0);
    vectors++;
    if (addr_ok !== 1'b1) begin miscompares++; $display("FAIL bp_accept addr_ok=%b want 1", addr_ok); end
    commit();
    for (int i = 0; i < 3; i++) begin
      cyc(i[0], 0, $urandom, 2'($urandom), 0, 0, 0);
      vectors++;
      if (arvalid !== 1'b1 || araddr !== a || addr_ok !== 1'b0)
        begin miscompares++; $display("FAIL bp_hold%0d arvalid=%b araddr=%h addr_ok=%b want 1 %h 0", i, arvalid, araddr, addr_ok, a); end
      commit();
    end
    cyc(0, 0, 0, 0, 1, 0, 0);
    vectors++;
    if (arvalid !== 1'b1 || araddr !== a)
      begin miscompares++; $display("FAIL bp_release arvalid=%b araddr=%h", arvalid, araddr); end
    commit();
    cyc(0, 0, 0, 0, 0, 1, word_of(a));
    vectors++;
    if (arvalid !== 1'b0 || data_ok !== 1'b1 || sram_rdata !== word_of(a))
      begin miscompares++; $display("FAIL bp_after arvalid=%b data_ok=%b rdata=%h want 0 1 %h", arvalid, data_ok, sram_rdata, word_of(a)); end
    commit();
  endtask

  task automatic test_outstanding_limit();
    int n;
    do_reset();
    n = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 32'h1c00_0100 + 32'(4 * i), 2, 1, 0, 0);
      if (addr_ok) n++;
      vectors++;
      if (addr_ok !== e_ok) begin miscompares++; $display("FAIL limit_fill%0d addr_ok=%b want %b", i, addr_ok, e_ok); end
      commit();
    end
    vectors++;
    if (n != MAX) begin miscompares++; $display("FAIL limit_count got %0d accepts want %0d", n, MAX); end
    cyc(1, 0, 32'h1c00_0200, 2, 1, 1, word_of(sq[0]));
    vectors++;
    if (data_ok !== 1'b1 || addr_ok !== 1'b0 || sram_rdata !== word_of(m_order[0]))
      begin miscompares++; $display("FAIL limit_ret data_ok=%b addr_ok=%b rdata=%h want 1 0 %h", data_ok, addr_ok, sram_rdata, word_of(m_order[0])); end
    commit();
    n = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 32'h1c00_0300 + 32'(4 * i), 2, 1, 0, 0);
      if (addr_ok) n++;
      commit();
    end
    vectors++;
    if (n != 1) begin miscompares++; $display("FAIL limit_refill got %0d accepts want 1", n); end
    drain();
  endtask

  task automatic test_simultaneous();
    logic [31:0] a, b;
    do_reset();
    a = 32'h1c00_0000; b = 32'h1c00_0004;
    cyc(1, 0, a, 2, 1, 0, 0); commit();
    cyc(0, 0, 0, 2, 1, 0, 0); commit();
    cyc(1, 0, b, 2, 1, 1, word_of(sq[0]));
    vectors++;
    if (addr_ok !== 1'b1 || data_ok !== 1'b1 || sram_rdata !== word_of(a))
      begin miscompares++; $display("FAIL sim_both addr_ok=%b data_ok=%b rdata=%h want 1 1 %h", addr_ok, data_ok, sram_rdata, word_of(a)); end
    commit();
    cyc(0, 0, 0, 2, 1, 0, 0);
    vectors++;
    if (arvalid !== 1'b1 || araddr !== b)
      begin miscompares++; $display("FAIL sim_ar arvalid=%b araddr=%h want 1 %h", arvalid, araddr, b); end
    commit();
    cyc(0, 0, 0, 2, 1, 1, word_of(sq[0]));
    vectors++;
    if (data_ok !== 1'b1 || sram_rdata !== word_of(b))
      begin miscompares++; $display("FAIL sim_second data_ok=%b rdata=%h want 1 %h", data_ok, sram_rdata, word_of(b)); end
    commit();
    cyc(0, 0, 0, 2, 1, 1, 32'h5555_aaaa);
    vectors++;
    if (data_ok !== 1'b0) begin miscompares++; $display("FAIL sim_cnt_one data_ok=%b want 0", data_ok); end
    commit();
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc(1, 0, 32'h1c00_0500, 2, 1, 0, 0); commit();
    cyc(1, 0, 32'h1c00_0504, 2, 1, 0, 0); commit();
    cyc(0, 0, 0, 2, 0, 0, 0);
    vectors++;
    if (arvalid !== 1'b1 || m_cnt != 2)
      begin miscompares++; $display("FAIL mid_setup arvalid=%b want 1 (model cnt %0d)", arvalid, m_cnt); end
    resetn = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (arvalid !== 1'b0 || addr_ok !== 1'b0)
      begin miscompares++; $display("FAIL mid_async arvalid=%b addr_ok=%b want 0 0", arvalid, addr_ok); end
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 2, 1, 1, 32'hbad0_0000 + 32'(i));
      vectors++;
      if (data_ok !== 1'b0) begin miscompares++; $display("FAIL mid_stale%0d data_ok=%b want 0", i, data_ok); end
      commit();
    end
    cyc(1, 0, 32'h1c00_0600, 2, 1, 0, 0);
    vectors++;
    if (addr_ok !== 1'b1) begin miscompares++; $display("FAIL mid_new addr_ok=%b want 1", addr_ok); end
    commit();
    cyc(0, 0, 0, 2, 1, 0, 0);
    vectors++;
    if (arvalid !== 1'b1 || araddr !== 32'h1c00_0600)
      begin miscompares++; $display("FAIL mid_new_ar arvalid=%b araddr=%h", arvalid, araddr); end
    commit();
    drain();
  endtask

  task automatic test_write_reject();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, $urandom, 2, 1'($urandom), 0, 0);
      vectors++;
      if (addr_ok !== 1'b0 || arvalid !== 1'b0)
        begin miscompares++; $display("FAIL wr_reject%0d addr_ok=%b arvalid=%b want 0 0", i, addr_ok, arvalid); end
      commit();
    end
  endtask

  task automatic test_random();
    bit rv;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rv = (sq.size() > 0) && ($urandom_range(0, 2) != 0);
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, {$urandom, 2'b00} ,
          2'($urandom), $urandom_range(0, 2) != 0, rv, rv ? word_of(sq[0]) : $urandom);
      vectors++;
      if (addr_ok !== e_ok || data_ok !== e_dok || arvalid !== m_pend)
        begin miscompares++; $display("FAIL rand%0d addr_ok=%b/%b data_ok=%b/%b arvalid=%b/%b (got/want)", i, addr_ok, e_ok, data_ok, e_dok, arvalid, m_pend); end
      if (m_pend) begin
        vectors++;
        if (araddr !== m_araddr || arsize !== {1'b0, m_size})
          begin miscompares++; $display("FAIL rand_ar%0d araddr=%h arsize=%b want %h %b", i, araddr, arsize, m_araddr, {1'b0, m_size}); end
      end
      if (e_dok) begin
        vectors++;
        if (sram_rdata !== word_of(m_order[0]))
          begin miscompares++; $display("FAIL rand_data%0d rdata=%h want %h", i, sram_rdata, word_of(m_order[0])); end
      end
      commit();
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b1; req = 0; wr = 0; size = 0; wstrb = 0; addr = 0; wdata = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    model_reset();
    test_reset();
    test_single_fetch();
    test_backpressure();
    test_outstanding_limit();
    test_simultaneous();
    test_reset_mid();
    test_write_reject();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
